// File: rtl/cpu_mem_arbiter.sv
// cpu_mem_arbiter: merges the instruction-fetch and data sram-like channels onto one
// sram-like memory port with a single outstanding transaction. Data has fixed priority
// over fetch unless ARB_ROUND_ROBIN_EN is defined, which alternates on simultaneous requests.
module cpu_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic              inst_cache,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [2:0]        data_size,
    input  logic [3:0]        data_wstrb,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    input  logic              data_cache,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [2:0]        mem_size,
    output logic [3:0]        mem_wstrb,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_cache,
    input  logic              mem_addr_ok,
    input  logic              mem_data_ok,
    input  logic [DATA_W-1:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
    state_t              state_q;
    logic                grant_q;
    logic                mem_req_q, mem_wr_q, mem_cache_q;
    logic [2:0]          mem_size_q;
    logic [3:0]          mem_wstrb_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic                win_d, latch_d;

    // a new request is taken from IDLE, or chained straight in as the previous response lands
    always_comb latch_d = (inst_req | data_req) & (state_q == IDLE | (state_q == WAIT & mem_data_ok));

`ifdef ARB_ROUND_ROBIN_EN
    logic last_grant_q;
    // on a tie the channel not served last wins; resetting to inst lets data win the first tie
    always_comb win_d = data_req & (~inst_req | ~last_grant_q);
    // remember the owner of every latched request
    always_ff @(posedge clk or posedge rst)
        if (rst) last_grant_q <= 1'b0;
        else if (latch_d) last_grant_q <= win_d;
`else
    // data always beats fetch
    always_comb win_d = data_req;
`endif

    // FSM: latch the winner's fields, present them until accepted, then await the response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_size_q  <= '0;
            mem_wstrb_q <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_cache_q <= 1'b0;
        end else if (latch_d) begin
            state_q     <= REQ;
            grant_q     <= win_d;
            mem_req_q   <= 1'b1;
            mem_wr_q    <= win_d & data_wr;
            mem_size_q  <= win_d ? data_size : 3'd2;
            mem_wstrb_q <= win_d ? data_wstrb : 4'd0;
            mem_addr_q  <= win_d ? data_addr : inst_addr;
            mem_wdata_q <= win_d ? data_wdata : '0;
            mem_cache_q <= win_d ? data_cache : inst_cache;
        end else if (state_q == REQ && mem_addr_ok) begin
            state_q   <= WAIT;
            mem_req_q <= 1'b0;
        end else if (state_q == WAIT && mem_data_ok) begin
            state_q <= IDLE;
        end
    end

    assign mem_req      = mem_req_q;
    assign mem_wr       = mem_wr_q;
    assign mem_size     = mem_size_q;
    assign mem_wstrb    = mem_wstrb_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign mem_cache    = mem_cache_q;
    assign inst_addr_ok = state_q == REQ & ~grant_q & mem_addr_ok;
    assign data_addr_ok = state_q == REQ & grant_q & mem_addr_ok;
    assign inst_data_ok = state_q == WAIT & ~grant_q & mem_data_ok;
    assign data_data_ok = state_q == WAIT & grant_q & mem_data_ok;
    assign inst_rdata   = inst_data_ok ? mem_rdata : '0;
    assign data_rdata   = data_data_ok ? mem_rdata : '0;
endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// tb_cpu_mem_arbiter: directed and randomized transactions against a transaction-level arbitration model
module tb_cpu_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req, inst_cache, inst_addr_ok, inst_data_ok;
    logic [31:0] inst_addr, inst_rdata;
    logic        data_req, data_wr, data_cache, data_addr_ok, data_data_ok;
    logic [2:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        mem_req, mem_wr, mem_cache, mem_addr_ok, mem_data_ok;
    logic [2:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;
    int inst_left, data_left;
    bit last_w;
    bit glog[$];
    bit rd_fix_en;
    logic [31:0] rd_fix;

    cpu_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_cache(inst_cache),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_cache(data_cache),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_cache(mem_cache),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // arbitration rule: with both requesting, round-robin serves whoever was not served last
    function automatic bit pick(input bit i, input bit d, input bit last);
`ifdef ARB_ROUND_ROBIN_EN
        return (i && d) ? !last : d;
`else
        return d;
`endif
    endfunction

    task automatic new_inst;
        inst_addr  = $urandom & 32'hFFFF_FFFC;
        inst_cache = 1'($urandom);
    endtask

    task automatic new_data;
        data_wr    = 1'($urandom);
        data_size  = 3'($urandom_range(0, 2));
        data_wstrb = 4'($urandom);
        data_addr  = $urandom;
        data_wdata = $urandom;
        data_cache = 1'($urandom);
    endtask

    task automatic all_zero(input string tag);
        chk({tag, " mem_req"}, mem_req, 0);
        chk({tag, " mem_wr"}, mem_wr, 0);
        chk({tag, " mem_size"}, mem_size, 0);
        chk({tag, " mem_wstrb"}, mem_wstrb, 0);
        chk({tag, " mem_addr"}, mem_addr, 0);
        chk({tag, " mem_wdata"}, mem_wdata, 0);
        chk({tag, " mem_cache"}, mem_cache, 0);
        chk({tag, " oks"}, {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, 0);
    endtask

    // serves ni fetches and nd data requests; entered at a quiet cycle just after a clock edge
    task automatic run(input int ni, input int nd, input int alat, input int dlat);
        bit w;
        int a, d;
        logic [31:0] ea, ewd, rd;
        logic ewr, ec;
        logic [2:0] esz;
        logic [3:0] est;
        inst_left = ni;
        data_left = nd;
        inst_req  = ni > 0;
        data_req  = nd > 0;
        if (ni + nd == 0) return;
        while (inst_req || data_req) begin
            w = pick(inst_req, data_req, last_w);
            last_w = w;
            ea  = w ? data_addr : inst_addr;
            ewr = w ? data_wr : 1'b0;
            esz = w ? data_size : 3'd2;
            est = w ? data_wstrb : 4'd0;
            ec  = w ? data_cache : inst_cache;
            ewd = data_wdata;
            tick;
            a = alat < 0 ? int'($urandom_range(0, 3)) : alat;
            for (int k = 0; k <= a; k++) begin
                mem_addr_ok = k == a;
                mem_data_ok = k != a && $urandom_range(0, 1) == 1;
                #1;
                chk("mem_req", mem_req, 1);
                chk("mem_addr", mem_addr, ea);
                chk("mem_wr", mem_wr, ewr);
                chk("mem_size", mem_size, esz);
                chk("mem_wstrb", mem_wstrb, est);
                chk("mem_cache", mem_cache, ec);
                if (w) chk("mem_wdata", mem_wdata, ewd);
                chk("inst_addr_ok", inst_addr_ok, k == a && !w);
                chk("data_addr_ok", data_addr_ok, k == a && w);
                chk("data_ok in REQ", {inst_data_ok, data_data_ok}, 0);
                if (k == a) glog.push_back(data_addr_ok);
                tick;
            end
            mem_addr_ok = 1'b0;
            if (w) begin
                data_left--;
                if (data_left > 0) new_data; else data_req = 1'b0;
            end else begin
                inst_left--;
                if (inst_left > 0) new_inst; else inst_req = 1'b0;
            end
            d  = dlat < 0 ? int'($urandom_range(0, 3)) : dlat;
            rd = rd_fix_en ? rd_fix : $urandom;
            for (int k = 0; k <= d; k++) begin
                mem_data_ok = k == d;
                mem_rdata   = k == d ? rd : $urandom;
                #1;
                chk("mem_req in WAIT", mem_req, 0);
                chk("addr_ok in WAIT", {inst_addr_ok, data_addr_ok}, 0);
                chk("inst_data_ok", inst_data_ok, k == d && !w);
                chk("data_data_ok", data_data_ok, k == d && w);
                if (k == d && !w) chk("inst_rdata", inst_rdata, rd);
                if (k == d && w) chk("data_rdata", data_rdata, rd);
                if (k < d) tick;
            end
        end
        tick;
        mem_data_ok = 1'b0;
        #1;
        chk("idle mem_req", mem_req, 0);
    endtask

    task automatic chk_order(input string tag, input bit exp[$]);
        chk({tag, " count"}, glog.size(), exp.size());
        for (int i = 0; i < exp.size() && i < glog.size(); i++) chk(tag, glog[i], exp[i]);
    endtask

    initial begin
        rst = 1'b1;
        inst_req = 0; inst_addr = 0; inst_cache = 0;
        data_req = 0; data_wr = 0; data_size = 0; data_wstrb = 0;
        data_addr = 0; data_wdata = 0; data_cache = 0;
        mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
        last_w = 0; rd_fix_en = 0; rd_fix = 0;
        #1;
        all_zero("reset");
        tick; tick;
        rst = 1'b0;
        tick;
        all_zero("after reset");

        // single fetch
        inst_addr = 32'hBFC0_0000; inst_cache = 1'b1;
        rd_fix_en = 1; rd_fix = 32'h3C1D_8000;
        glog.delete();
        run(1, 0, 1, 1);
        chk_order("single fetch grant", '{1'b0});
        rd_fix_en = 0;

        // collision: data write goes first, fetch chained after it
        new_inst;
        data_wr = 1; data_size = 3'd2; data_wstrb = 4'hF;
        data_addr = 32'h8000_1000; data_wdata = 32'hDEAD_BEEF; data_cache = 0;
        glog.delete();
        run(1, 1, -1, -1);
        chk_order("collision grant", '{1'b1, 1'b0});

        // both channels keep requesting
        new_inst; new_data;
        glog.delete();
        run(3, 3, -1, -1);
`ifdef ARB_ROUND_ROBIN_EN
        chk_order("continuous grant", '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
`else
        chk_order("continuous grant", '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
`endif

        // data held for 5 transactions against a waiting fetch
        new_inst; new_data;
        glog.delete();
        run(1, 5, -1, -1);
`ifdef ARB_ROUND_ROBIN_EN
        chk_order("starvation grant", '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1});
`else
        chk_order("starvation grant", '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0});
`endif

        // stalled addr_ok for 10 cycles
        new_data;
        glog.delete();
        run(0, 1, 10, -1);
        chk_order("stall grant", '{1'b1});

        // randomized traffic
        for (int n = 0; n < 25; n++) begin
            new_inst; new_data;
            run(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), -1, -1);
            tick;
        end

        // reset while waiting for the response
        new_data;
        data_addr = data_addr | 32'h100;
        data_req = 1;
        tick;
        mem_addr_ok = 1;
        #1;
        chk("pre-reset data_addr_ok", data_addr_ok, 1);
        tick;
        data_req = 0; mem_addr_ok = 0;
        #3;
        mem_data_ok = 1; mem_rdata = 32'h1234_5678;
        #1;
        chk("pre-reset data_data_ok", data_data_ok, 1);
        rst = 1;
        #1;
        all_zero("reset in WAIT");
        chk("reset data_rdata", data_rdata, 0);
        mem_data_ok = 0;
        tick;
        rst = 0;
        last_w = 0;
        tick;
        mem_data_ok = 1;
        #1;
        chk("stale data_ok", {inst_data_ok, data_data_ok}, 0);
        chk("stale mem_req", mem_req, 0);
        tick;
        mem_data_ok = 0;
        new_inst; new_data;
        glog.delete();
        run(1, 1, -1, -1);
        chk_order("post-reset grant", '{1'b1, 1'b0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cpu_mem_arbiter.md
# cpu_mem_arbiter

Merges the core's instruction-fetch and data-access sram-like channels onto one sram-like memory port, for the single-ported AXI bridge outside `cpu_core`. Grants one requester at a time, registers the winning request, and keeps exactly one transaction outstanding. Routes the `addr_ok` and `data_ok` pulses and the read data back to the granted channel. Default arbitration is fixed data-over-instruction priority; round-robin is a compile option.

## Interface
Parameters:
- `ADDR_W`, 32, address width on all three channels
- `DATA_W`, 32, read/write data width

Ports:
- `clk`  in  1  core clock
- `rst`  in  1  asynchronous reset, active-high
- `inst_req`  in  1  fetch request, held until `inst_addr_ok`
- `inst_addr`  in  ADDR_W  fetch physical address
- `inst_cache`  in  1  fetch cacheable attribute
- `inst_addr_ok`  out  1  one-cycle pulse: fetch request accepted by memory
- `inst_data_ok`  out  1  one-cycle pulse: fetch data valid on `inst_rdata`
- `inst_rdata`  out  DATA_W  fetch read data
- `data_req`  in  1  data request, held until `data_addr_ok`
- `data_wr`  in  1  1 = write
- `data_size`  in  3  access size code
- `data_wstrb`  in  4  byte strobes
- `data_addr`  in  ADDR_W  data physical address
- `data_wdata`  in  DATA_W  write data
- `data_cache`  in  1  data cacheable attribute
- `data_addr_ok`  out  1  one-cycle pulse: data request accepted
- `data_data_ok`  out  1  one-cycle pulse: data read data or write response
- `data_rdata`  out  DATA_W  data read data
- `mem_req`, `mem_wr`, `mem_size[2:0]`, `mem_wstrb[3:0]`, `mem_addr[ADDR_W]`, `mem_wdata[DATA_W]`, `mem_cache`  out  merged request, all registered
- `mem_addr_ok`  in  1  memory accepted the request
- `mem_data_ok`  in  1  memory response valid
- `mem_rdata`  in  DATA_W  memory read data

## Operation
- **FSM states:** IDLE, REQ, WAIT. Register `grant` records the owner: 0 = inst, 1 = data.
- **IDLE:**
  - If any `*_req` is high, arbitrate.
  - Latch the winner's fields into the `mem_*` registers, set `grant`, go to REQ.
  - An instruction winner latches `mem_wr`=0, `mem_wstrb`=0, `mem_size`=2.
- **REQ:**
  - `mem_req`=1.
  - On `mem_addr_ok`: pulse `<grant>_addr_ok`, drop `mem_req`, go to WAIT.
  - `mem_data_ok` in REQ is a protocol error and is ignored.
- **WAIT:**
  - On `mem_data_ok`: pulse `<grant>_data_ok`. `inst_rdata` and `data_rdata` pass `mem_rdata` through combinationally.
  - If any `*_req` is high that same cycle (excluding the channel just accepted, whose req is already low), arbitrate, latch, and go directly to REQ. Otherwise go to IDLE.
- **Arbitration (default):** `data_req` wins over `inst_req`.
- **Locked request:** a requester's request fields are not re-sampled after latching. Requesters must hold stable fields until `addr_ok`; the arbiter forwards only the latched copy.
- **No-drop guarantee:** a non-granted requester keeps `req` high and is served later. No request is ever dropped.
- **Reset mid-transaction:**
  - The FSM returns to IDLE and all outputs go to 0.
  - An outstanding memory response is not tracked. The system resets the bridge simultaneously.

## Timing
- **Reset values:** `mem_req`, `mem_wr`, `mem_size`, `mem_wstrb`, `mem_addr`, `mem_wdata`, `mem_cache` = 0; `inst_addr_ok`, `inst_data_ok`, `data_addr_ok`, `data_data_ok` = 0; state = IDLE; `grant`=0; `last_grant`=0.
- **Request latency:** `*_req` rises in cycle N while IDLE → `mem_req`=1 in N+1.
- **`addr_ok` latency:** the `*_addr_ok` pulse occurs in the same cycle as `mem_addr_ok` (combinational from state, `grant` and `mem_addr_ok`).
- **`data_ok` latency:** the `*_data_ok` pulse occurs in the same cycle as `mem_data_ok`.
- **Back-to-back throughput:** one transaction per (2 + memory latency) cycles from IDLE, or per (1 + memory latency) cycles when chained through WAIT→REQ.
- **`rdata` validity:** `*_rdata` is meaningful only while the matching `*_data_ok` is high.

## Configuration
- **`ARB_ROUND_ROBIN_EN` defined:**
  - Register `last_grant` updates to the winner on every latch.
  - On simultaneous requests, the channel that is not `last_grant` wins.
  - `last_grant` resets to 0, so data wins the first tie.
- **Not defined:** fixed data priority; `last_grant` is not synthesized; instruction fetch can starve under continuous data traffic.

## Test plan
1. **Single fetch.** Stimulus: `inst_req`=1 with `inst_addr`=0xBFC00000; memory gives `mem_addr_ok` 1 cycle after `mem_req`, then `mem_data_ok` with `mem_rdata`=0x3C1D8000 2 cycles later. Required: `mem_addr`=0xBFC00000 and `mem_wr`=0; exactly one `inst_addr_ok` pulse and one `inst_data_ok` pulse; `inst_rdata`=0x3C1D8000; no `data_*_ok` pulse.
2. **Collision.** Stimulus: `inst_req` and a `data_req` write (`data_addr`=0x80001000, `data_wdata`=0xDEADBEEF, `data_wstrb`=0xF) in the same cycle. Required: the data request is issued first with `mem_wr`=1 and `mem_wdata`=0xDEADBEEF; the fetch is issued after the data `data_ok` via the WAIT→REQ chain with no IDLE cycle.
3. **Round-robin.** Stimulus: same as scenario 2 with `ARB_ROUND_ROBIN_EN`, inst and data both continuously requesting for 6 transactions. Required: grant order is data, inst, data, inst, data, inst.
4. **Fixed-priority starvation.** Stimulus: `data_req` held high for 5 transactions without the macro, `inst_req` also high. Required: 5 data grants, then the inst grant only after `data_req` falls.
5. **Reset in WAIT.** Stimulus: assert `rst` while in WAIT. Required: all outputs become 0 immediately (asynchronously); a `mem_data_ok` arriving after reset release produces no `*_data_ok` pulse.
6. **Stalled `addr_ok`.** Stimulus: `mem_addr_ok` withheld for 10 cycles. Required: `mem_req` and all `mem_*` fields stay constant; no `*_addr_ok` pulse until `mem_addr_ok` rises.
